tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Time-division 4-channel demultiplexer; the receive-side counterpart of the 4:1 select mux.
- Takes a serial stream carrying four slots per frame (slot order i0, i1, i2, i3), aligns to a frame-sync marker, and distributes each slot to its own registered output.
- Updates all four outputs atomically at frame end.
- Sits after the mux / serial link in the datapath.

Parameters:
- WIDTH, 1, bit width of each slot sample and of each output.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- din  input  WIDTH  serial slot sample
- din_valid  input  1  din carries a sample this cycle
- frame_sync  input  1  qualified by din_valid; marks din as slot 0 of a new frame
- y0  output  WIDTH  channel 0 (slot 0) held value
- y1  output  WIDTH  channel 1 (slot 1) held value
- y2  output  WIDTH  channel 2 (slot 2) held value
- y3  output  WIDTH  channel 3 (slot 3) held value
- s1  output  1  slot counter MSB; next slot expected
- s0  output  1  slot counter LSB
- frame_valid  output  1  one-cycle pulse: new frame published on y0..y3
- sync_err  output  1  one-cycle pulse: frame_sync arrived mid-frame

Behaviour:
- Reset (rst_n low, asynchronous): y0..y3=0, {s1,s0}=0, frame_valid=0, sync_err=0, staging regs=0, state=IDLE.
- States:
  - IDLE: waiting for alignment.
  - RUN: aligned.
- Sample accept: din_valid=1 at a rising edge. Cycles with din_valid=0 change nothing; frame_valid and sync_err deassert.
- frame_sync is ignored when din_valid=0.
- IDLE:
  - Accept with frame_sync=0 -> discarded, stay IDLE.
  - Accept with frame_sync=1 -> stage slot 0, {s1,s0}=1, go RUN.
- RUN, accept with frame_sync=0 at slot k:
  - k=0..2: stage into staging[k]; {s1,s0}=k+1.
  - k=3: same edge loads y0..y2 from staging and y3 from din; frame_valid=1 for the next cycle; {s1,s0} wraps to 0.
- RUN, accept with frame_sync=1:
  - {s1,s0}=0: normal slot 0.
  - {s1,s0}!=0: partial frame discarded, y0..y3 unchanged, sync_err=1 next cycle, din staged as slot 0, {s1,s0}=1.
- Latency: y0..y3 and frame_valid change on the edge that accepts slot 3 (visible in the following cycle). No other edge alters y0..y3.
- Back-to-back frames at one sample per cycle: frame_valid pulses every 4th cycle; no bubbles required.
- frame_valid and sync_err never assert in the same cycle.
- rst_n asserted mid-frame: immediate return to reset values, state=IDLE; partial frame lost.

Optional Feature:
- Macro: TDM_SYNC_LOSS_EN
- Defined: in RUN, an accept at {s1,s0}=0 with frame_sync=0 is a sync loss.
  - Sample discarded, state -> IDLE, {s1,s0}=0, sync_err pulses one cycle.
  - y0..y3 hold their last values.
- Undefined: frame_sync optional after alignment. Counter free-runs, and frame_sync=0 at slot 0 is accepted as normal slot 0.

Test Plan:
- Reset then frame: sync+din=0,1,0,1 on 4 consecutive valid cycles -> after the 4th edge y0=0 y1=1 y2=0 y3=1, frame_valid high exactly 1 cycle, {s1,s0}=00.
- Pre-sync garbage: 3 valid samples with frame_sync=0 in IDLE, then aligned frame 1,1,0,0 -> y=1,1,0,0; the 3 garbage samples have no effect; single frame_valid.
- Gaps: frame 1,0,1,1 with din_valid=0 for 2 cycles between every sample -> y=1,0,1,1, one frame_valid after the last sample; y unchanged during gaps.
- Mid-frame resync: frame 1,1,1,1 published; next frame 0,0 then frame_sync with 1,0,1,0 -> sync_err pulses once, y stays 1,1,1,1 until the new frame completes, then y=1,0,1,0.
- Async reset mid-frame: rst_n low for half a cycle after slot 1 -> all outputs 0 immediately; next frame requires frame_sync.
- TDM_SYNC_LOSS_EN defined: two frames with sync only on the first -> second frame's slot 0 dropped, sync_err=1, state IDLE, y holds first frame. Undefined: the second frame publishes normally.

Source files
------------

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive-side 4-slot time-division demultiplexer.
// A serial stream carries four slots per frame (i0..i3). The block aligns to
// frame_sync, stages slots 0..2 and publishes all four outputs together on
// the edge that accepts slot 3.
// Optional build macro TDM_SYNC_LOSS_EN: when defined, a missing frame_sync
// at slot 0 while aligned is a sync loss (sample dropped, back to IDLE).
//
// Handshake: a sample is accepted on a rising clk edge where din_valid=1;
// there is no back-pressure. frame_sync is only meaningful when din_valid=1.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             s1,
  output logic             s0,
  output logic             frame_valid,
  output logic             sync_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Current alignment state; kept as a named signal so checkers can bind to it.
  state_t           state;
  logic [1:0]       slot;
  logic [WIDTH-1:0] stg0;
  logic [WIDTH-1:0] stg1;
  logic [WIDTH-1:0] stg2;

  assign s1 = slot[1];
  assign s0 = slot[0];

  // Alignment FSM, slot counter, staging and atomic publish of the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot        <= 2'd0;
      stg0        <= '0;
      stg1        <= '0;
      stg2        <= '0;
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      // Status flags are single-cycle pulses.
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state)
          IDLE: begin
            // Samples before the first frame_sync are discarded.
            if (frame_sync) begin
              stg0  <= din;
              slot  <= 2'd1;
              state <= RUN;
            end
          end
          RUN: begin
            if (frame_sync) begin
              // A sync mid-frame drops the partial frame and restarts at slot 0.
              if (slot != 2'd0) begin
                sync_err <= 1'b1;
              end
              stg0 <= din;
              slot <= 2'd1;
            end else begin
`ifdef TDM_SYNC_LOSS_EN
              if (slot == 2'd0) begin
                // Expected a sync marker here: alignment is lost.
                sync_err <= 1'b1;
                slot     <= 2'd0;
                state    <= IDLE;
              end else begin
`else
              begin
`endif
                case (slot)
                  2'd0: stg0 <= din;
                  2'd1: stg1 <= din;
                  2'd2: stg2 <= din;
                  default: begin
                    y0          <= stg0;
                    y1          <= stg1;
                    y2          <= stg2;
                    y3          <= din;
                    frame_valid <= 1'b1;
                  end
                endcase
                slot <= slot + 2'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed-vector bench for tdm_demux4 (WIDTH=1).
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic [0:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [0:0] y0, y1, y2, y3;
  logic       s1, s0;
  logic       frame_valid;
  logic       sync_err;

  int total = 0;
  int bad   = 0;

  tdm_demux4 #(.WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .s1(s1), .s0(s0), .frame_valid(frame_valid), .sync_err(sync_err)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] y_all;
  logic [1:0] s_all;
  assign y_all = {y0, y1, y2, y3};
  assign s_all = {s1, s0};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one accepted sample; returns at the following negedge.
  task automatic send(input logic d, input logic s);
    @(negedge clk);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = s;
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    din        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    idle(2);
    chk("reset_y", {4'b0, y_all}, 8'h00);
    chk("reset_s", {6'b0, s_all}, 8'h00);
    chk("reset_flags", {6'b0, frame_valid, sync_err}, 8'h00);
    rst_n = 1'b1;

    // Frame 0,1,0,1 with sync on slot 0
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    chk("f1_s_before_last", {6'b0, s_all}, 8'h03);
    chk("f1_fv_before_last", {7'b0, frame_valid}, 8'h00);
    send(1'b1, 1'b0);
    chk("f1_y", {4'b0, y_all}, 8'h05);
    chk("f1_fv", {7'b0, frame_valid}, 8'h01);
    chk("f1_s_wrap", {6'b0, s_all}, 8'h00);
    idle(1);
    chk("f1_fv_one_cycle", {7'b0, frame_valid}, 8'h00);

    // Pre-sync garbage ignored in IDLE
    do_reset();
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    chk("garbage_s", {6'b0, s_all}, 8'h00);
    chk("garbage_y", {4'b0, y_all}, 8'h00);
    chk("garbage_fv", {7'b0, frame_valid}, 8'h00);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    chk("f2_y", {4'b0, y_all}, 8'h0C);
    chk("f2_fv", {7'b0, frame_valid}, 8'h01);

    // Gaps of two idle cycles between samples
    send(1'b1, 1'b1); idle(2);
    send(1'b0, 1'b0); idle(2);
    send(1'b1, 1'b0); idle(2);
    chk("gap_y_hold", {4'b0, y_all}, 8'h0C);
    chk("gap_fv_low", {7'b0, frame_valid}, 8'h00);
    chk("gap_s", {6'b0, s_all}, 8'h03);
    send(1'b1, 1'b0);
    chk("gap_y", {4'b0, y_all}, 8'h0B);
    chk("gap_fv", {7'b0, frame_valid}, 8'h01);

    // Mid-frame resync
    send(1'b1, 1'b1); send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
    chk("rs_y_first", {4'b0, y_all}, 8'h0F);
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    chk("rs_s_partial", {6'b0, s_all}, 8'h02);
    send(1'b1, 1'b1);
    chk("rs_err", {7'b0, sync_err}, 8'h01);
    chk("rs_fv_low", {7'b0, frame_valid}, 8'h00);
    chk("rs_y_hold", {4'b0, y_all}, 8'h0F);
    chk("rs_s_restart", {6'b0, s_all}, 8'h01);
    idle(1);
    chk("rs_err_one_cycle", {7'b0, sync_err}, 8'h00);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("rs_y_hold2", {4'b0, y_all}, 8'h0F);
    send(1'b0, 1'b0);
    chk("rs_y_new", {4'b0, y_all}, 8'h0A);
    chk("rs_fv", {7'b0, frame_valid}, 8'h01);
    chk("rs_err_clear", {7'b0, sync_err}, 8'h00);

    // Asynchronous reset mid-frame, between clock edges
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_y", {4'b0, y_all}, 8'h00);
    chk("ar_s", {6'b0, s_all}, 8'h00);
    #2 rst_n = 1'b1;
    send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
    chk("ar_nosync_y", {4'b0, y_all}, 8'h00);
    chk("ar_nosync_fv", {7'b0, frame_valid}, 8'h00);
    chk("ar_nosync_s", {6'b0, s_all}, 8'h00);
    send(1'b0, 1'b1); send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
    chk("ar_y_new", {4'b0, y_all}, 8'h06);

    // Second frame without sync
    send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    chk("sl_y_first", {4'b0, y_all}, 8'h09);
    send(1'b0, 1'b0);
`ifdef TDM_SYNC_LOSS_EN
    chk("sl_err", {7'b0, sync_err}, 8'h01);
    chk("sl_s", {6'b0, s_all}, 8'h00);
    send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
    chk("sl_y_hold", {4'b0, y_all}, 8'h09);
    chk("sl_fv", {7'b0, frame_valid}, 8'h00);
    chk("sl_s_idle", {6'b0, s_all}, 8'h00);
`else
    chk("sl_err", {7'b0, sync_err}, 8'h00);
    chk("sl_s", {6'b0, s_all}, 8'h01);
    send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
    chk("sl_y_new", {4'b0, y_all}, 8'h06);
    chk("sl_fv", {7'b0, frame_valid}, 8'h01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
